// File: rtl/cw305_aes_sequencer.sv
// cw305_aes_sequencer
// Runs the AES core from the crypto_clk domain. Two sources can start a run: the
// register GO pulse and the rising edge of the asynchronous usb_trigger pin. A run
// reloads the key if it has changed since the last key load. It then performs
// 1 + I_batch chained encryptions, where each ciphertext becomes the next plaintext.
// While the core runs, the block drives the scope trigger. It captures the final
// ciphertext and reports busy/done/error status.
//
// Ports
//   crypto_clk, reset_i           clock, async active-high reset
//   I_go, I_usb_trigger           start sources (pulse / async level)
//   I_key_changed                 key register was written
//   I_textin, I_batch             first plaintext, extra chained encryptions
//   I_clear_err                   clears the sticky error flags
//   O_busy, O_done, O_cipherout   status and result to the register block
//   O_trigger                     scope trigger, high while the core runs
//   O_timeout_err, O_overrun      sticky error flags
//   O_core_key_load, O_core_load  core command pulses
//   O_core_pt                     plaintext to the core
//   I_core_ready, I_core_done     core handshake
//   I_core_ct                     core ciphertext
module cw305_aes_sequencer #(
    parameter int pBATCH_W = 8,
    parameter int pTIMEOUT = 1024
) (
    input  logic                crypto_clk,
    input  logic                reset_i,
    input  logic                I_go,
    input  logic                I_usb_trigger,
    input  logic                I_key_changed,
    input  logic [127:0]        I_textin,
    input  logic [pBATCH_W-1:0] I_batch,
    input  logic                I_clear_err,
    output logic                O_busy,
    output logic                O_trigger,
    output logic                O_done,
    output logic [127:0]        O_cipherout,
    output logic                O_timeout_err,
    output logic                O_overrun,
    output logic                O_core_key_load,
    output logic                O_core_load,
    output logic [127:0]        O_core_pt,
    input  logic                I_core_ready,
    input  logic                I_core_done,
    input  logic [127:0]        I_core_ct
);

    localparam int WD_W = (pTIMEOUT > 2) ? $clog2(pTIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, KEY, LOAD, RUN} state_t;

    state_t              state, state_nxt;
    logic                trig_meta, trig_sync, trig_prev;
    logic                trig_rise, start_req;
    logic                key_pending;
    logic [pBATCH_W-1:0] remaining;
    logic [WD_W-1:0]     wd_cnt;
    logic                wd_expired;

    logic accept, capture, chain, timeout_hit, overrun_set;
    logic key_load_nxt, load_nxt, done_nxt, trigger_nxt;

    assign trig_rise  = trig_sync & ~trig_prev;
    assign start_req  = I_go | trig_rise;
    assign wd_expired = (wd_cnt == WD_W'(pTIMEOUT - 1));

    // The O_done cycle still counts as busy, so a request that lands on the
    // done pulse is dropped instead of starting a new run.
    assign O_busy = (state != IDLE) | O_done;

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        capture      = 1'b0;
        chain        = 1'b0;
        timeout_hit  = 1'b0;
        key_load_nxt = 1'b0;
        load_nxt     = 1'b0;
        done_nxt     = 1'b0;
        trigger_nxt  = O_trigger;
        overrun_set  = start_req & O_busy;
        case (state)
            IDLE: begin
                if (start_req && !O_done) begin
                    accept    = 1'b1;
                    state_nxt = key_pending ? KEY : LOAD;
                end
            end
            KEY: begin
                if (wd_expired) begin
                    timeout_hit = 1'b1;
                end else if (I_core_ready) begin
                    key_load_nxt = 1'b1;
                    state_nxt    = LOAD;
                end
            end
            LOAD: begin
                if (wd_expired) begin
                    timeout_hit = 1'b1;
                end else if (I_core_ready) begin
                    load_nxt    = 1'b1;
                    trigger_nxt = 1'b1;
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                // A completion in the timeout cycle still counts as a success.
                if (I_core_done) begin
                    capture     = 1'b1;
                    trigger_nxt = 1'b0;
                    if (remaining == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        chain     = 1'b1;
                        state_nxt = LOAD;
                    end
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (timeout_hit) begin
            trigger_nxt = 1'b0;
            state_nxt   = IDLE;
        end
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            trig_meta       <= 1'b0;
            trig_sync       <= 1'b0;
            trig_prev       <= 1'b0;
            key_pending     <= 1'b1;
            remaining       <= '0;
            wd_cnt          <= '0;
            O_trigger       <= 1'b0;
            O_done          <= 1'b0;
            O_cipherout     <= '0;
            O_timeout_err   <= 1'b0;
            O_overrun       <= 1'b0;
            O_core_key_load <= 1'b0;
            O_core_load     <= 1'b0;
            O_core_pt       <= '0;
        end else begin
            state           <= state_nxt;
            trig_meta       <= I_usb_trigger;
            trig_sync       <= trig_meta;
            trig_prev       <= trig_sync;
            O_trigger       <= trigger_nxt;
            O_done          <= done_nxt;
            O_core_key_load <= key_load_nxt;
            O_core_load     <= load_nxt;

            // A key write coinciding with the key load must not be lost.
            if (I_key_changed)     key_pending <= 1'b1;
            else if (key_load_nxt) key_pending <= 1'b0;

            // The watchdog restarts on every state entry and idles at zero.
            if (state_nxt != state || state == IDLE) wd_cnt <= '0;
            else                                     wd_cnt <= wd_cnt + 1'b1;

            if (accept) begin
                O_core_pt <= I_textin;
                remaining <= I_batch;
            end else if (chain) begin
                O_core_pt <= I_core_ct;
                remaining <= remaining - 1'b1;
            end

            if (capture) O_cipherout <= I_core_ct;

            if (I_clear_err)      O_timeout_err <= 1'b0;
            else if (timeout_hit) O_timeout_err <= 1'b1;

            if (I_clear_err)      O_overrun <= 1'b0;
            else if (overrun_set) O_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cw305_aes_sequencer.sv
// Bench for cw305_aes_sequencer. The core is a stand-in with a fixed latency.
// It "encrypts" by 128-bit addition of the loaded key (ct = pt + key). That makes
// chaining and key loading visible while keeping expected values hand-checkable.
module tb_cw305_aes_sequencer;

    localparam int     BW   = 8;
    localparam int     TO   = 1024;
    localparam int     LAT  = 4;
    localparam [127:0] KEY  = 128'habcdef0112345678deadbeef87654321;
    localparam [127:0] PT   = 128'h12345678abcdef0187654321deadbeef;
    localparam [127:0] CT1  = 128'hbe024579be02457a6613021166130210; // PT + KEY

    logic          crypto_clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          I_go = 1'b0, I_usb_trigger = 1'b0, I_key_changed = 1'b0, I_clear_err = 1'b0;
    logic [127:0]  I_textin = PT;
    logic [BW-1:0] I_batch = '0;
    logic          O_busy, O_trigger, O_done, O_timeout_err, O_overrun;
    logic          O_core_key_load, O_core_load;
    logic [127:0]  O_cipherout, O_core_pt;
    logic          I_core_ready, I_core_done;
    logic [127:0]  I_core_ct;

    cw305_aes_sequencer #(.pBATCH_W(BW), .pTIMEOUT(TO)) dut (
        .crypto_clk(crypto_clk), .reset_i(reset_i), .I_go(I_go),
        .I_usb_trigger(I_usb_trigger), .I_key_changed(I_key_changed),
        .I_textin(I_textin), .I_batch(I_batch), .I_clear_err(I_clear_err),
        .O_busy(O_busy), .O_trigger(O_trigger), .O_done(O_done),
        .O_cipherout(O_cipherout), .O_timeout_err(O_timeout_err),
        .O_overrun(O_overrun), .O_core_key_load(O_core_key_load),
        .O_core_load(O_core_load), .O_core_pt(O_core_pt),
        .I_core_ready(I_core_ready), .I_core_done(I_core_done), .I_core_ct(I_core_ct)
    );

    always #5 crypto_clk = ~crypto_clk;

    // core stand-in
    logic         core_hang = 1'b0;
    logic         core_busy, core_done;
    logic [127:0] core_key = '0, core_ptl, core_ct;
    int           core_cnt;
    assign I_core_ready = ~core_busy;
    assign I_core_done  = core_done;
    assign I_core_ct    = core_ct;

    always @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            core_busy <= 1'b0;
            core_done <= 1'b0;
            core_cnt  <= 0;
            core_ct   <= '0;
        end else begin
            core_done <= 1'b0;
            if (O_core_key_load) core_key <= KEY;
            if (O_core_load && !core_hang) begin
                core_busy <= 1'b1;
                core_cnt  <= LAT;
                core_ptl  <= O_core_pt;
            end else if (core_busy) begin
                if (core_cnt == 1) begin
                    core_done <= 1'b1;
                    core_ct   <= core_ptl + core_key;
                    core_busy <= 1'b0;
                end
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // event monitors
    int n_keyld = 0, n_load = 0, n_done = 0, n_trig = 0;
    logic [127:0] pts [0:511];
    always @(negedge crypto_clk) begin
        if (!reset_i) begin
            if (O_core_key_load) n_keyld++;
            if (O_core_load) begin
                if (n_load < 512) pts[n_load] = O_core_pt;
                n_load++;
            end
            if (O_done) n_done++;
            if (O_trigger) n_trig++;
        end
    end

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge crypto_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input int bound, output logic found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            tick();
            if (O_done) found = 1'b1;
        end
    endtask

    task automatic pulse_go();
        I_go = 1'b1;
        tick();
        I_go = 1'b0;
    endtask

    logic [127:0] exp_v;
    logic         found;
    int kl0, ld0, dn0, tr0;

    initial begin
        // reset state
        ticks(2);
        check("rst_busy", O_busy, 0);
        check("rst_trig", O_trigger, 0);
        check("rst_cipher", O_cipherout, 0);
        check("rst_flags", {O_done, O_timeout_err, O_overrun, O_core_key_load, O_core_load}, 0);
        reset_i = 1'b0;
        ticks(2);

        // 1: key reload then a single encryption, with exact latencies
        kl0 = n_keyld; ld0 = n_load; dn0 = n_done;
        I_key_changed = 1'b1; tick(); I_key_changed = 1'b0;
        pulse_go();                                   // edge 1 -> KEY
        check("t1_busy_rise", O_busy, 1);
        check("t1_keyld_early", O_core_key_load, 0);
        I_key_changed = 1'b1;                         // collides with the key load
        tick();                                       // edge 2
        I_key_changed = 1'b0;
        check("t1_keyld_lat", O_core_key_load, 1);
        tick();                                       // edge 3
        check("t1_load_lat", {O_core_load, O_trigger}, 2'b11);
        wait_done(50, found);
        check("t1_done_seen", found, 1);
        check("t1_busy_at_done", O_busy, 1);
        check("t1_cipher", O_cipherout, CT1);
        tick();
        check("t1_busy_fall", O_busy, 0);
        check("t1_counts", {8'(n_keyld - kl0), 8'(n_load - ld0), 8'(n_done - dn0)}, {8'd1, 8'd1, 8'd1});

        // 1b: key change collided with the key load, so it must still be pending
        kl0 = n_keyld;
        pulse_go();
        wait_done(50, found);
        check("t1b_done_seen", found, 1);
        check("t1b_keyld_again", n_keyld - kl0, 1);
        ticks(2);

        // 2: usb trigger level held 10 cycles -> one run, no key load
        kl0 = n_keyld; ld0 = n_load; dn0 = n_done; tr0 = n_trig;
        I_usb_trigger = 1'b1;
        ticks(10);
        I_usb_trigger = 1'b0;
        ticks(20);
        check("t2_counts", {8'(n_keyld - kl0), 8'(n_load - ld0), 8'(n_done - dn0)}, {8'd0, 8'd1, 8'd1});
        check("t2_trig_cycles", n_trig - tr0, LAT + 2);
        check("t2_cipher", O_cipherout, CT1);
        check("t2_overrun", O_overrun, 0);

        // 3: batch of 2 -> three chained encryptions
        ld0 = n_load; dn0 = n_done;
        I_batch = 8'd2;
        pulse_go();
        wait_done(100, found);
        check("t3_done_seen", found, 1);
        ticks(2);
        check("t3_counts", {8'(n_load - ld0), 8'(n_done - dn0)}, {8'd3, 8'd1});
        check("t3_pt0", pts[ld0], PT);
        check("t3_pt1", pts[ld0 + 1], CT1);
        check("t3_pt2", pts[ld0 + 2], CT1 + KEY);
        check("t3_cipher", O_cipherout, PT + KEY + KEY + KEY);

        // 3b: all-ones batch -> 256 encryptions, no wrap
        ld0 = n_load; dn0 = n_done;
        I_batch = '1;
        pulse_go();
        I_batch = '0;
        wait_done(3000, found);
        check("t3b_done_seen", found, 1);
        ticks(2);
        exp_v = PT;
        for (int i = 0; i < 256; i++) exp_v = exp_v + KEY;
        check("t3b_loads", n_load - ld0, 256);
        check("t3b_dones", n_done - dn0, 1);
        check("t3b_cipher", O_cipherout, exp_v);

        // 4: GO coincident with trigger edge, then GO mid-RUN
        ld0 = n_load; dn0 = n_done;
        I_usb_trigger = 1'b1;
        ticks(2);                                     // edge now visible to the FSM
        pulse_go();
        check("t4_busy", O_busy, 1);
        check("t4_no_overrun", O_overrun, 0);
        tick();
        check("t4_in_run", O_trigger, 1);
        pulse_go();
        check("t4_overrun", O_overrun, 1);
        ticks(15);
        check("t4_counts", {8'(n_load - ld0), 8'(n_done - dn0)}, {8'd1, 8'd1});
        I_usb_trigger = 1'b0;
        I_clear_err = 1'b1; tick(); I_clear_err = 1'b0;
        check("t4_clear", O_overrun, 0);
        // request on the O_done cycle is dropped
        ld0 = n_load;
        pulse_go();
        wait_done(50, found);
        check("t4b_done_seen", found, 1);
        pulse_go();
        check("t4b_overrun_at_done", O_overrun, 1);
        ticks(15);
        check("t4b_loads", n_load - ld0, 1);
        check("t4b_idle", O_busy, 0);
        // clear wins over a same-cycle set
        pulse_go();
        I_go = 1'b1; I_clear_err = 1'b1;
        tick();
        I_go = 1'b0; I_clear_err = 1'b0;
        check("t4c_clear_prio", O_overrun, 0);
        wait_done(50, found);
        check("t4c_done_seen", found, 1);
        tick();

        // 5: core never completes -> watchdog timeout
        dn0 = n_done; tr0 = n_trig;
        exp_v = O_cipherout;
        core_hang = 1'b1;
        pulse_go();
        found = 1'b0;
        for (int i = 0; i < TO + 50 && !found; i++) begin
            tick();
            if (O_timeout_err) found = 1'b1;
        end
        core_hang = 1'b0;
        check("t5_timeout", found, 1);
        check("t5_idle", {O_busy, O_trigger}, 2'b00);
        check("t5_trig_cycles", n_trig - tr0, TO);
        check("t5_no_done", n_done - dn0, 0);
        check("t5_cipher_kept", O_cipherout, exp_v);
        pulse_go();
        wait_done(50, found);
        check("t5_recover", found, 1);
        check("t5_err_sticky", O_timeout_err, 1);
        I_clear_err = 1'b1; tick(); I_clear_err = 1'b0;
        check("t5_err_clear", O_timeout_err, 0);

        // 6: reset mid-RUN, then the next run reloads the key
        pulse_go();
        ticks(3);
        check("t6_running", O_trigger, 1);
        reset_i = 1'b1;
        #1;
        check("t6_rst_status", {O_busy, O_trigger, O_done, O_timeout_err, O_overrun}, 0);
        check("t6_rst_core", {O_core_key_load, O_core_load}, 0);
        check("t6_rst_cipher", O_cipherout, 0);
        check("t6_rst_pt", O_core_pt, 0);
        tick();
        reset_i = 1'b0;
        ticks(2);
        kl0 = n_keyld;
        pulse_go();
        wait_done(50, found);
        check("t6_done_seen", found, 1);
        check("t6_key_reload", n_keyld - kl0, 1);
        check("t6_cipher", O_cipherout, CT1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
